// File: rtl/code_ram_arbiter.sv
// code_ram_arbiter: shares one single-port code RAM between an instruction-fetch
// port (read-only) and a data port (read/write). Round-robin arbitration, one
// acceptance per cycle, fully pipelined one-cycle read responses routed by a
// registered tag. Out-of-range accesses never reach the RAM, and a read of one
// returns zero data.
module code_ram_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 40000
) (
   input  logic              clk,
   input  logic              reset_n,
   // instruction-fetch port
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic              i_waitrequest,
   output logic [31:0]       i_readdata,
   output logic              i_readdatavalid,
   // data port
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [3:0]        d_byteenable,
   input  logic [31:0]       d_writedata,
   output logic              d_waitrequest,
   output logic [31:0]       d_readdata,
   output logic              d_readdatavalid,
   // RAM port
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_address,
   output logic [3:0]        ram_byteenable,
   output logic [31:0]       ram_writedata,
   input  logic [31:0]       ram_readdata,
   // status
   output logic              err_oor,
   output logic [15:0]       grant_cnt_i,
   output logic [15:0]       grant_cnt_d
);

   typedef enum logic {
      GRANT_FETCH = 1'b0,
      GRANT_DATA  = 1'b1
   } grant_e;

   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   // flops
   grant_e      last_grant_q, last_grant_d;
   logic        rsp_valid_q,  rsp_valid_d;
   logic        rsp_port_q,   rsp_port_d;   // 1'b1 = data port
   logic        rsp_oor_q,    rsp_oor_d;
   logic        err_oor_q,    err_oor_d;
   logic [15:0] cnt_i_q,      cnt_i_d;
   logic [15:0] cnt_d_q,      cnt_d_d;

   // combinational arbitration signals
   logic              i_req;
   logic              d_req;
   logic              grant_i;
   logic              grant_d;
   logic              accept;
   logic              is_read;
   logic              oor;
   logic [ADDR_W-1:0] sel_addr;

   // Round-robin grant: on contention the port not granted last wins; nothing is granted in reset.
   always_comb begin
      i_req   = i_read;
      d_req   = d_read | d_write;
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (!reset_n) begin
         grant_i = 1'b0;
         grant_d = 1'b0;
      end else if (i_req && d_req) begin
         if (last_grant_q == GRANT_DATA) begin
            grant_i = 1'b1;
         end else begin
            grant_d = 1'b1;
         end
      end else if (i_req) begin
         grant_i = 1'b1;
      end else if (d_req) begin
         grant_d = 1'b1;
      end else begin
         grant_i = 1'b0;
         grant_d = 1'b0;
      end
      accept  = grant_i | grant_d;
      // a simultaneous read+write on the data port is a write
      is_read = grant_i | (grant_d & ~d_write);
      if (grant_d) begin
         sel_addr = d_address;
      end else if (grant_i) begin
         sel_addr = i_address;
      end else begin
         sel_addr = '0;
      end
      oor = accept && (32'(sel_addr) >= DEPTH_U);
   end

   // Drive the RAM in the acceptance cycle; out-of-range accesses leave it idle.
   always_comb begin
      ram_chipselect = accept & ~oor;
      ram_write      = grant_d & d_write & ~oor;
      ram_address    = ram_chipselect ? sel_addr : '0;
      if (!ram_chipselect) begin
         ram_byteenable = 4'h0;
      end else if (grant_d) begin
         ram_byteenable = d_byteenable;
      end else begin
         ram_byteenable = 4'hF;
      end
      ram_writedata  = ram_write ? d_writedata : 32'h0000_0000;
   end

   // Waitrequest: high in reset, high for a requesting loser, low otherwise.
   always_comb begin
      i_waitrequest = ~reset_n | (i_req & ~grant_i);
      d_waitrequest = ~reset_n | (d_req & ~grant_d);
   end

   // Next-state: response tag, error pulse, counters and round-robin pointer.
   always_comb begin
      rsp_valid_d  = accept & is_read;
      rsp_port_d   = grant_d;
      rsp_oor_d    = oor;
      err_oor_d    = oor;
      cnt_i_d      = cnt_i_q + {15'd0, grant_i};
      cnt_d_d      = cnt_d_q + {15'd0, grant_d};
      if (grant_d) begin
         last_grant_d = GRANT_DATA;
      end else if (grant_i) begin
         last_grant_d = GRANT_FETCH;
      end else begin
         last_grant_d = last_grant_q;
      end
   end

   // State registers; reset discards any in-flight response and lets fetch win first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= GRANT_DATA;
         rsp_valid_q  <= 1'b0;
         rsp_port_q   <= 1'b0;
         rsp_oor_q    <= 1'b0;
         err_oor_q    <= 1'b0;
         cnt_i_q      <= 16'h0000;
         cnt_d_q      <= 16'h0000;
      end else begin
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_port_q   <= rsp_port_d;
         rsp_oor_q    <= rsp_oor_d;
         err_oor_q    <= err_oor_d;
         cnt_i_q      <= cnt_i_d;
         cnt_d_q      <= cnt_d_d;
      end
   end

   // Route the RAM word to the originating port; zero when invalid or out-of-range.
   always_comb begin
      i_readdatavalid = rsp_valid_q & ~rsp_port_q;
      d_readdatavalid = rsp_valid_q &  rsp_port_q;
      i_readdata      = (i_readdatavalid && !rsp_oor_q) ? ram_readdata : 32'h0000_0000;
      d_readdata      = (d_readdatavalid && !rsp_oor_q) ? ram_readdata : 32'h0000_0000;
      err_oor         = err_oor_q;
      grant_cnt_i     = cnt_i_q;
      grant_cnt_d     = cnt_d_q;
   end

endmodule
